bit_feed_ctrl: RTL and testbench
================================

BIT_FEED_CTRL -- requirements
Module: bit_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 98, maximum bitstream length in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of decoded-symbol buffer entries.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have: reset  in  1  synchronous, active-high; sampled on rising clk.
REQ-005 SHALL have: start  in  1  request to load and stream a bitstream.
REQ-006 SHALL have: load_data  in  DATA_W  packed bitstream; bit len-1 is sent first.
REQ-007 SHALL have: load_len  in  7  bitstream length, legal range 1..DATA_W.
REQ-008 SHALL have: bit_out  out  1  serial bit to the decoder.
REQ-009 SHALL have: bit_valid  out  1  bit_out is presented to the decoder this cycle.
REQ-010 SHALL have: dec_valid  in  1  decoder reports one completed symbol.
REQ-011 SHALL have: dec_sym  in  7  7-bit ASCII symbol from the decoder.
REQ-012 SHALL have: sym_out  out  7  FIFO head symbol.
REQ-013 SHALL have: sym_valid  out  1  FIFO is non-empty.
REQ-014 SHALL have: out_ready  in  1  consumer accepts sym_out.
REQ-015 SHALL have: sym_count  out  6  symbols accepted this run, saturating at 63.
REQ-016 SHALL have: busy, done, err, ovf  out  1 each  status flags.

Function
REQ-017 SHALL implement states IDLE, SHIFT, STALL, DRAIN, DONE.
REQ-018 IDLE: start=1 with 1<=load_len<=DATA_W SHALL capture load_data and load_len, set index=load_len, clear sym_count and ovf, and enter SHIFT next cycle.
REQ-019 IDLE: start=1 with load_len=0 or load_len>DATA_W SHALL pulse err for one cycle and remain in IDLE.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 SHIFT: bit_valid=1 and bit_out=data[index-1]; index SHALL decrement by 1 each SHIFT cycle.
REQ-022 SHIFT with index=1 SHALL emit the final bit and move to DRAIN next cycle.
REQ-023 Whenever FIFO occupancy >= FIFO_DEPTH-1, SHIFT SHALL move to STALL; one slot is reserved for the decoder's in-flight symbol.
REQ-024 STALL: bit_valid=0 and index held; SHALL return to SHIFT when occupancy < FIFO_DEPTH-1.
REQ-025 In SHIFT, STALL and DRAIN, dec_valid=1 SHALL push dec_sym into the FIFO and increment sym_count, saturating at 63.
REQ-026 Pop SHALL occur when sym_valid=1 and out_ready=1; sym_out SHALL show the oldest entry.
REQ-027 A push and a pop in the same cycle SHALL leave occupancy unchanged, and this SHALL hold even when the FIFO is full.
REQ-028 A push into a full FIFO without a pop SHALL drop the symbol, leave sym_count unchanged, and set ovf sticky until the next accepted start or reset.
REQ-029 DRAIN: bit_valid=0; SHALL move to DONE on the first cycle the FIFO is empty and dec_valid=0.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE; sym_count SHALL hold until the next accepted start.
REQ-031 busy SHALL be 1 in SHIFT, STALL and DRAIN, and 0 otherwise.
REQ-032 dec_valid in IDLE or DONE SHALL be ignored.

Reset
REQ-033 reset=1 SHALL, at the next rising clk, force IDLE, index=0, FIFO empty, and sym_count=0.
REQ-034 During and after reset, bit_out, bit_valid, sym_out, sym_valid, busy, done, err and ovf SHALL all be 0.
REQ-035 reset SHALL take priority over start, dec_valid and out_ready in the same cycle.
REQ-036 reset mid-run SHALL abort the run immediately, discarding FIFO contents.

Verification
REQ-037 Pass criteria:
- load_len=4, load_data=...1011, out_ready=1, no dec_valid -> bit_out 1,0,1,1 with bit_valid over 4 cycles -> DRAIN -> done pulse on cycle 6 after start.
- start with load_len=0 -> err pulse, busy stays 0; load_len=99 -> same result.
- load_len=98, out_ready=0, dec_valid on every 3rd bit -> stall at occupancy 3, bit_valid=0; release out_ready -> resumes; total 98 bit_valid cycles.
- Full FIFO, out_ready=0, forced dec_valid -> ovf=1, sym_count unchanged; simultaneous pop+push at full -> occupancy stays 4, ovf unchanged.
- reset asserted on 10th SHIFT cycle -> next cycle IDLE with all outputs 0; new start runs from the first bit.
- 70 dec_valid pulses in one run with out_ready=1 -> sym_count=63 (saturated), ovf=0.

Source files
------------

// File: rtl/bit_feed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bit_feed_ctrl                                                   |
// | Purpose  : Streams a loaded bitstream MSB-first (bit len-1 first) to a     |
// |            serial decoder and buffers the decoded 7-bit symbols in a small |
// |            FIFO. Bit streaming is throttled so the FIFO always keeps one   |
// |            free slot for a symbol the decoder may still be producing.      |
// | Ports    : clk, reset      - clock, synchronous active-high reset          |
// |            start           - load request (honoured only when idle)        |
// |            load_data/len   - packed bitstream and its length (1..DATA_W)   |
// |            bit_out/valid   - serial bit to the decoder                     |
// |            dec_valid/sym   - completed symbol from the decoder             |
// |            sym_out/valid   - FIFO head, consumer handshake via out_ready   |
// |            sym_count       - symbols accepted this run (saturates at 63)   |
// |            busy/done/err/ovf - status flags                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bit_feed_ctrl #(
  parameter int DATA_W     = 98,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] load_data,
  input  logic [6:0]        load_len,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              dec_valid,
  input  logic [6:0]        dec_sym,
  output logic [6:0]        sym_out,
  output logic              sym_valid,
  input  logic              out_ready,
  output logic [5:0]        sym_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [7:0]       LEN_MAX  = 8'(DATA_W);
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_AT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] EMPTY    = '0;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    STALL = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] data;
  logic [6:0]        index;

  logic [6:0]        sym_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ;

  logic len_ok;
  logic accept_start;
  logic active;
  logic push_req;
  logic push;
  logic pop;
  logic drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign len_ok       = (load_len != 7'd0) && ({1'b0, load_len} <= LEN_MAX);
  assign accept_start = (state == IDLE) && start && len_ok;
  assign active       = (state == SHIFT) || (state == STALL) || (state == DRAIN);

  // A full FIFO still accepts a symbol when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign sym_valid = (occ != EMPTY);
  assign sym_out   = sym_valid ? sym_mem[rd_ptr] : 7'd0;
  assign pop       = sym_valid && out_ready;
  assign push_req  = active && dec_valid;
  assign push      = push_req && ((occ != FULL_AT) || pop);
  assign drop      = push_req && (occ == FULL_AT) && !pop;

  // Next state and per-state outputs
  always_comb begin
    state_nxt = state;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept_start) state_nxt = SHIFT;
      end
      SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = data[index - 7'd1];
        busy      = 1'b1;
        // The final bit always goes out and hands over to DRAIN; otherwise
        // pause when only the reserved slot is left.
        if (index == 7'd1)        state_nxt = DRAIN;
        else if (occ >= STALL_AT) state_nxt = STALL;
      end
      STALL: begin
        busy = 1'b1;
        if (occ < STALL_AT) state_nxt = SHIFT;
      end
      DRAIN: begin
        busy = 1'b1;
        if ((occ == EMPTY) && !dec_valid) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      data      <= '0;
      index     <= 7'd0;
      sym_count <= 6'd0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (state == IDLE) && start && !len_ok;
      if (accept_start) begin
        data      <= load_data;
        index     <= load_len;
        sym_count <= 6'd0;
        ovf       <= 1'b0;
      end else begin
        if (state == SHIFT) index <= index - 7'd1;
        if (push && (sym_count != 6'd63)) sym_count <= sym_count + 6'd1;
        if (drop) ovf <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= EMPTY;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once pushed
  always_ff @(posedge clk) begin
    if (push) sym_mem[wr_ptr] <= dec_sym;
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_feed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bit_feed_ctrl                                                |
// | Purpose  : Self-checking bench for bit_feed_ctrl: queue-based reference    |
// |            model compared every cycle plus directed literal expectations.  |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bit_feed_ctrl;

  localparam int DATA_W     = 98;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] load_data;
  logic [6:0]        load_len;
  logic              bit_out;
  logic              bit_valid;
  logic              dec_valid;
  logic [6:0]        dec_sym;
  logic [6:0]        sym_out;
  logic              sym_valid;
  logic              out_ready;
  logic [5:0]        sym_count;
  logic              busy;
  logic              done;
  logic              err;
  logic              ovf;

  always #5 clk = ~clk;

  bit_feed_ctrl #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .load_data (load_data),
    .load_len  (load_len),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .dec_valid (dec_valid),
    .dec_sym   (dec_sym),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .out_ready (out_ready),
    .sym_count (sym_count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ovf       (ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Run state is a queue of bits still to send and a queue of buffered symbols.
  bit         m_run, m_stall, m_done, m_err, m_ovf;
  logic       m_bits[$];
  logic [6:0] m_syms[$];
  int         m_count;
  bit         chk_en = 1'b0;

  task automatic model_step();
    int occ;
    bit do_pop, do_push;
    logic [DATA_W-1:0] d;
    if (reset) begin
      m_run = 0; m_stall = 0; m_done = 0; m_err = 0; m_ovf = 0; m_count = 0;
      m_bits.delete();
      m_syms.delete();
      return;
    end
    occ     = m_syms.size();
    do_pop  = (occ > 0) && out_ready;
    do_push = m_run && dec_valid;
    m_err   = 0;
    if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (start) begin
        if ((load_len >= 1) && (int'(load_len) <= DATA_W)) begin
          m_bits.delete();
          d = load_data;
          for (int i = int'(load_len) - 1; i >= 0; i--) m_bits.push_back(d[i]);
          m_run = 1; m_stall = 0; m_count = 0; m_ovf = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_bits.size() > 0) begin
      if (!m_stall) begin
        void'(m_bits.pop_front());
        if ((m_bits.size() > 0) && (occ >= FIFO_DEPTH - 1)) m_stall = 1;
      end else if (occ < FIFO_DEPTH - 1) begin
        m_stall = 0;
      end
    end else if ((occ == 0) && !dec_valid) begin
      m_run  = 0;
      m_done = 1;
    end
    if (do_pop) void'(m_syms.pop_front());
    if (do_push) begin
      if ((occ < FIFO_DEPTH) || do_pop) begin
        m_syms.push_back(dec_sym);
        if (m_count < 63) m_count++;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin : compare_proc
    logic ev;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ev = m_run && (m_bits.size() > 0) && !m_stall;
        check("bit_valid", bit_valid, ev);
        check("bit_out", bit_out, ev ? m_bits[0] : 1'b0);
        check("sym_valid", sym_valid, m_syms.size() > 0);
        check("sym_out", sym_out, (m_syms.size() > 0) ? m_syms[0] : 7'd0);
        check("sym_count", sym_count, m_count);
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("err", err, m_err);
        check("ovf", ovf, m_ovf);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic kick(input logic [6:0] len, input logic [DATA_W-1:0] d);
    @(negedge clk);
    start = 1'b1; load_len = len; load_data = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check(name, k < budget, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0]        bits4;
    logic [27:0]       got;
    logic [29:0]       got30;
    logic [DATA_W-1:0] d98;
    int nb, done_at, nbits, stalls, npop;
    bit done_seen;

    d98 = 98'h3_1234_5678_9ABC_DEF0_1357_9BDF;
    reset = 1'b1; start = 1'b0; load_data = '0; load_len = 7'd0;
    dec_valid = 1'b0; dec_sym = 7'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_symv", sym_valid, 1'b0);
    check("rst_count", sym_count, 6'd0);
    reset = 1'b0;

    // T1: 4-bit stream, done on cycle 6 after start
    out_ready = 1'b1;
    kick(7'd4, 98'b1011);
    bits4 = '0; nb = 0; done_at = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (bit_valid) begin bits4 = {bits4[2:0], bit_out}; nb++; end
      if (done && (done_at == 0)) done_at = k;
    end
    check("t1_bits", bits4, 4'b1011);
    check("t1_nbits", nb, 4);
    check("t1_done_cycle", done_at, 6);

    // T2: illegal lengths
    kick(7'd0, '0);
    check("t2_err_len0", err, 1'b1);
    check("t2_busy_len0", busy, 1'b0);
    @(negedge clk);
    check("t2_err_clear", err, 1'b0);
    kick(7'd99, '0);
    check("t2_err_len99", err, 1'b1);
    check("t2_busy_len99", busy, 1'b0);

    // T3: full-length stream, symbol every 3rd bit, consumer stalled at first
    out_ready = 1'b0; nbits = 0; stalls = 0; done_seen = 0;
    kick(7'd98, d98);
    for (int k = 0; (k < 1000) && !done_seen; k++) begin
      if (k > 0) @(negedge clk);
      if (done) done_seen = 1;
      if (bit_valid) begin
        nbits++;
        dec_valid = (nbits % 3 == 0);
        dec_sym   = 7'(nbits);
      end else begin
        dec_valid = 1'b0;
        if (busy && (nbits < 98)) stalls++;
      end
      if ((stalls == 6) && !out_ready) begin
        check("t3_stall_bv", bit_valid, 1'b0);
        check("t3_stall_nbits", nbits, 10);
        out_ready = 1'b1;
      end
    end
    dec_valid = 1'b0;
    check("t3_nbits", nbits, 98);
    check("t3_done", done_seen, 1'b1);
    check("t3_stalled", stalls >= 6, 1'b1);
    @(negedge clk);
    check("t3_count", sym_count, 6'd32);

    // T4: overflow at full, then push+pop at full
    out_ready = 1'b0;
    kick(7'd20, d98);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      dec_valid = 1'b1; dec_sym = 7'h40 + 7'(k);
    end
    @(negedge clk);
    check("t4_ovf", ovf, 1'b1);
    check("t4_count", sym_count, 6'd4);
    check("t4_head", sym_out, 7'h41);
    out_ready = 1'b1; dec_valid = 1'b1; dec_sym = 7'h46;
    @(negedge clk);
    dec_valid = 1'b0;
    check("t4_count_pp", sym_count, 6'd5);
    check("t4_ovf_pp", ovf, 1'b1);
    got = '0; npop = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (!sym_valid) break;
      got = {got[20:0], sym_out}; npop++;
    end
    check("t4_npop", npop, 4);
    check("t4_order", got, {7'h42, 7'h43, 7'h44, 7'h46});
    wait_done("t4_done", 100);
    check("t4_ovf_sticky", ovf, 1'b1);

    // T5: reset on the 10th bit, then a clean rerun
    out_ready = 1'b0; nb = 0;
    kick(7'd30, d98);
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (bit_valid) nb++;
      dec_valid = bit_valid && ((nb == 2) || (nb == 3));
      if (nb == 10) break;
    end
    dec_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_bv", bit_valid, 1'b0);
    check("t5_symv", sym_valid, 1'b0);
    out_ready = 1'b1; got30 = '0; nb = 0;
    kick(7'd30, d98);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (bit_valid) begin got30 = {got30[28:0], bit_out}; nb++; end
      if (nb == 30) break;
    end
    check("t5_bits", got30, d98[29:0]);
    wait_done("t5_done", 50);

    // T6: 70 symbols saturate the counter; late start/dec_valid ignored
    out_ready = 1'b1;
    kick(7'd98, d98);
    for (int k = 0; k < 70; k++) begin
      if (k > 0) @(negedge clk);
      dec_valid = 1'b1; dec_sym = 7'(k);
      start = (k == 10); load_len = 7'd0;
    end
    @(negedge clk);
    dec_valid = 1'b0; start = 1'b0;
    wait_done("t6_done", 200);
    @(negedge clk);
    dec_valid = 1'b1; dec_sym = 7'h55;
    repeat (2) @(negedge clk);
    dec_valid = 1'b0;
    check("t6_count", sym_count, 6'd63);
    check("t6_ovf", ovf, 1'b0);
    check("t6_idle_symv", sym_valid, 1'b0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
